io_timer: RTL

- Memory-mapped 8-bit timer/counter peripheral on the CPU data/IO bus. Occupies 4 bytes in the IO window 0x1000-0x10FF, which is reachable with the CPU's IO-address form {8'h10, imm8}.
- Drives one of the CPU's interrupt_N inputs and consumes the matching interrupt_N_clr acknowledge.
- Provides a prescaled counter, compare match, optional clear-on-match (CTC) and a sticky match flag.

---
 rtl/io_timer_pkg.sv | 32 +++
 rtl/timer_prescaler.sv | 38 +++
 rtl/io_timer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/io_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_timer_pkg
// Description : Register offsets, CTRL/STAT bit positions and the prescaler
//               mask helper shared by the io_timer peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
package io_timer_pkg;

    // Register offsets within the 4-byte block
    localparam logic [1:0] TMR_CTRL = 2'd0;
    localparam logic [1:0] TMR_CMP  = 2'd1;
    localparam logic [1:0] TMR_CNT  = 2'd2;
    localparam logic [1:0] TMR_STAT = 2'd3;

    // CTRL bit positions
    localparam int EN_BIT  = 0;
    localparam int CTC_BIT = 1;
    localparam int IE_BIT  = 2;
    localparam int PSC_LSB = 3;
    localparam int PSC_MSB = 5;

    // STAT bit positions
    localparam int MF_BIT  = 0;

    // Prescaler mask (1 << psc) - 1; psc = 7 wraps to 7'h7F in 7 bits.
    function automatic logic [6:0] psc_mask(input logic [2:0] psc);
        return (7'd1 << psc) - 7'd1;
    endfunction

endpackage : io_timer_pkg
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : timer_prescaler
// Description : Free-running 7-bit prescaler. Produces a one-cycle tick
//               whenever the low PSC bits of the count are all ones.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_prescaler
    import io_timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [2:0] psc,
    output logic       tick
);

    logic [6:0] r_count;
    logic [6:0] w_mask;

    assign w_mask = psc_mask(psc);

    // Count while enabled; hold at zero while disabled so enabling restarts
    // the prescale period from a known phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 7'd0;
        end else if (!en) begin
            r_count <= 7'd0;
        end else begin
            r_count <= r_count + 7'd1;
        end
    end

    assign tick = en && ((r_count & w_mask) == w_mask);

endmodule : timer_prescaler
`default_nettype wire

// File: rtl/io_timer.sv
`default_nettype none
// ============================================================================
// Module      : io_timer
// Description : Memory-mapped 8-bit timer/counter on the CPU IO bus with
//               prescaler, compare match, clear-on-match, sticky match flag
//               and a maskable interrupt request.
// Revision    : 1.0 - initial release
// ============================================================================
module io_timer
    import io_timer_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h1010,
    parameter logic [7:0]  RESET_CMP = 8'hFF
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  din,
    input  logic        write_en,
    input  logic        read_en,
    output logic [7:0]  dout,
    output logic        irq,
    input  logic        irq_clr
);

    // Architectural state
    logic [5:0] r_ctrl;     // CTRL bits [7:6] are not stored; they read 0
    logic [7:0] r_cmp;
    logic [7:0] r_cnt;
    logic       r_mf;

    // Decode and datapath wires
    logic       w_sel;
    logic [1:0] w_offset;
    logic       w_wrSel;
    logic       w_wrCtrl;
    logic       w_wrCmp;
    logic       w_wrCnt;
    logic       w_wrStat;
    logic       w_tick;
    logic       w_match;
    logic       w_mfSet;
    logic       w_mfClr;
    logic       w_mfNext;
    logic [7:0] w_readData;

    assign w_sel    = (address[15:2] == BASE_ADDR[15:2]);
    assign w_offset = address[1:0];
    assign w_wrSel  = write_en && w_sel;
    assign w_wrCtrl = w_wrSel && (w_offset == TMR_CTRL);
    assign w_wrCmp  = w_wrSel && (w_offset == TMR_CMP);
    assign w_wrCnt  = w_wrSel && (w_offset == TMR_CNT);
    assign w_wrStat = w_wrSel && (w_offset == TMR_STAT);

    timer_prescaler u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (r_ctrl[EN_BIT]),
        .psc   (r_ctrl[PSC_MSB:PSC_LSB]),
        .tick  (w_tick)
    );

    // Match always compares against the pre-edge CMP, so a CMP write on a
    // tick cycle cannot affect that cycle's match.
    assign w_match = (r_cnt == r_cmp);

    // A CPU write to CNT on a tick cycle suppresses match evaluation.
    assign w_mfSet  = w_tick && w_match && !w_wrCnt;
    assign w_mfClr  = irq_clr || (w_wrStat && din[MF_BIT]);
    // Set beats clear so a match coinciding with an acknowledge is not lost.
    assign w_mfNext = w_mfSet ? 1'b1 : (w_mfClr ? 1'b0 : r_mf);

    // Control and compare registers: plain CPU-writable storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl <= 6'd0;
            r_cmp  <= RESET_CMP;
        end else begin
            if (w_wrCtrl) begin
                r_ctrl <= din[5:0];
            end
            if (w_wrCmp) begin
                r_cmp <= din;
            end
        end
    end

    // Counter: CPU write has priority, otherwise advance or clear on tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 8'd0;
        end else if (w_wrCnt) begin
            r_cnt <= din;
        end else if (w_tick) begin
            if (w_match && r_ctrl[CTC_BIT]) begin
                r_cnt <= 8'd0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // Sticky match flag and registered, IE-masked interrupt request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mf <= 1'b0;
            irq  <= 1'b0;
        end else begin
            r_mf <= w_mfNext;
            irq  <= w_mfNext && r_ctrl[IE_BIT];
        end
    end

    // Read mux selecting the addressed register's current value.
    always_comb begin
        w_readData = 8'd0;
        case (w_offset)
            TMR_CTRL: w_readData = {2'b00, r_ctrl};
            TMR_CMP:  w_readData = r_cmp;
            TMR_CNT:  w_readData = r_cnt;
            TMR_STAT: w_readData = {7'd0, r_mf};
            default:  w_readData = 8'd0;
        endcase
    end

    // Registered read data; zero when idle so it can be OR-ed onto the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= 8'd0;
        end else if (read_en && w_sel) begin
            dout <= w_readData;
        end else begin
            dout <= 8'd0;
        end
    end

endmodule : io_timer
`default_nettype wire
